picomips_ctrl: RTL and testbench

PICOMIPS_CTRL -- requirements
Module: picomips_ctrl

---
 rtl/picomips_ctrl_if.sv | 27 ++
 rtl/picomips_ctrl.sv | 123 ++++++++++++
 tb/tb_picomips_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/picomips_ctrl_if.sv
// Control/datapath bundle between the picoMIPS controller and its program memory, ALU and regfile.
// The master modport is the controller side.
interface picomips_ctrl_if #(
  parameter int unsigned n   = 8,
  parameter int unsigned pcw = 6
);
  logic [19:0]    instr;
  logic [2:0]     flags;
  logic [pcw-1:0] pc;
  logic [2:0]     func;
  logic [2:0]     rd_addr;
  logic [2:0]     rs_addr;
  logic [n-1:0]   imm;
  logic           imm_sel;
  logic           w_en;
  logic           halt;

  modport master (
    input  instr, flags,
    output pc, func, rd_addr, rs_addr, imm, imm_sel, w_en, halt
  );

  modport slave (
    output instr, flags,
    input  pc, func, rd_addr, rs_addr, imm, imm_sel, w_en, halt
  );
endinterface

// File: rtl/picomips_ctrl.sv
// picoMIPS controller: two-cycle FETCH/EXEC sequencer with instruction and flag registers.
// It decodes ALU controls and resolves branches against the previously stored flags.
module picomips_ctrl #(
  parameter int unsigned n   = 8,
  parameter int unsigned pcw = 6
) (
  input logic              clk,
  input logic              nReset,
  picomips_ctrl_if.master  bus
);

  typedef enum logic [1:0] {StFetch, StExec, StHalted} state_e;

  typedef enum logic [2:0] {
    AluRa, AluRb, AluAdd, AluSub, AluAnd, AluOr, AluXor, AluNor
  } alu_e;

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpAdd  = 4'h1;
  localparam logic [3:0] OpSub  = 4'h2;
  localparam logic [3:0] OpAnd  = 4'h3;
  localparam logic [3:0] OpOr   = 4'h4;
  localparam logic [3:0] OpXor  = 4'h5;
  localparam logic [3:0] OpNor  = 4'h6;
  localparam logic [3:0] OpMov  = 4'h7;
  localparam logic [3:0] OpAddi = 4'h8;
  localparam logic [3:0] OpSubi = 4'h9;
  localparam logic [3:0] OpBeq  = 4'hA;
  localparam logic [3:0] OpBne  = 4'hB;
  localparam logic [3:0] OpJmp  = 4'hC;
  localparam logic [3:0] OpHalt = 4'hF;

  state_e         state_q, state_d;
  logic [pcw-1:0] pc_q, pc_d;
  logic [19:0]    ir_q, ir_d;
  logic [2:0]     f_q, f_d;
  logic           halt_q, halt_d;

  logic [3:0]     op;
  logic [pcw-1:0] target;
  logic [pcw-1:0] pc_inc;
  logic           alu_op;
  alu_e           func;
  logic           imm_sel;
  logic           unused_ir;

  assign op        = ir_q[19:16];
  assign target    = pcw'(ir_q[7:0]);
  assign pc_inc    = pc_q + pcw'(1);
  assign alu_op    = (op >= OpAdd) && (op <= OpSubi);
  assign unused_ir = ^ir_q[9:8];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    f_d     = f_q;
    halt_d  = halt_q;
    func    = AluRa;
    imm_sel = 1'b0;

    unique case (state_q)
      StFetch: begin
        ir_d    = bus.instr;
        state_d = StExec;
      end
      StExec: begin
        state_d = StFetch;
        pc_d    = pc_inc;
        if (alu_op) f_d = bus.flags;
        case (op)
          OpAdd:   func = AluAdd;
          OpSub:   func = AluSub;
          OpAnd:   func = AluAnd;
          OpOr:    func = AluOr;
          OpXor:   func = AluXor;
          OpNor:   func = AluNor;
          OpMov:   func = AluRb;
          OpAddi:  begin func = AluAdd; imm_sel = 1'b1; end
          OpSubi:  begin func = AluSub; imm_sel = 1'b1; end
          // Branches use f_q: the flags stored by the last ALU instruction.
          OpBeq:   if (f_q[0])  pc_d = target;
          OpBne:   if (!f_q[0]) pc_d = target;
          OpJmp:   pc_d = target;
          OpHalt:  begin
            pc_d    = pc_q;
            state_d = StHalted;
            halt_d  = 1'b1;
          end
          default: ;
        endcase
      end
      StHalted: ;
      default:  state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= StFetch;
      pc_q    <= '0;
      ir_q    <= '0;
      f_q     <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      f_q     <= f_d;
      halt_q  <= halt_d;
    end
  end

  assign bus.pc      = pc_q;
  assign bus.func    = func;
  assign bus.rd_addr = ir_q[15:13];
  assign bus.rs_addr = ir_q[12:10];
  assign bus.imm     = n'(ir_q[7:0]);
  assign bus.imm_sel = imm_sel;
  assign bus.w_en    = (state_q == StExec) && alu_op;
  assign bus.halt    = halt_q;

endmodule

// File: tb/tb_picomips_ctrl.sv
// Directed bench for picomips_ctrl: a small program in a behavioural ROM exercises ALU decode,
// flag capture, branches, pc wrap, halt and asynchronous reset.
module tb_picomips_ctrl;

  logic clk;
  logic nReset;
  logic [19:0] mem [64];
  int nvec;
  int nerr;

  picomips_ctrl_if #(.n(8), .pcw(6)) bus ();

  picomips_ctrl #(.n(8), .pcw(6)) dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  assign bus.instr = mem[bus.pc];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    nReset = 1'b0;
    bus.flags = 3'b000;
    for (int i = 0; i < 64; i++) mem[i] = 20'h00000;
    mem[0]    = 20'h10400;  // ADD r0,r1
    mem[1]    = 20'h84005;  // ADDI r2,5
    mem[2]    = 20'hA002A;  // BEQ 0x2A
    mem[6'h2A] = 20'h22800; // SUB r1,r2
    mem[6'h2B] = 20'hB0010; // BNE 0x10
    mem[6'h10] = 20'hA0010; // BEQ 0x10 (not taken)
    mem[6'h11] = 20'hC003F; // JMP 0x3F
    mem[6'h3F] = 20'hD0000; // op D behaves as NOP
    mem[5]    = 20'h57000;  // XOR r3,r4
    mem[6]    = 20'h72000;  // MOV r1,r0
    mem[7]    = 20'hF0000;  // HALT

    #2;
    chk("rst_pc", 32'(bus.pc), 32'h0);
    chk("rst_halt", 32'(bus.halt), 32'h0);
    chk("rst_wen", 32'(bus.w_en), 32'h0);
    chk("rst_func", 32'(bus.func), 32'h0);

    @(negedge clk);
    nReset = 1'b1;
    chk("fetch0_wen", 32'(bus.w_en), 32'h0);
    chk("fetch0_func", 32'(bus.func), 32'h0);

    tick();  // EXEC ADD
    chk("add_func", 32'(bus.func), 32'h2);
    chk("add_isel", 32'(bus.imm_sel), 32'h0);
    chk("add_wen", 32'(bus.w_en), 32'h1);
    chk("add_rd", 32'(bus.rd_addr), 32'h0);
    chk("add_rs", 32'(bus.rs_addr), 32'h1);
    chk("add_pc", 32'(bus.pc), 32'h0);
    mem[0] = 20'hC00C5;     // later: JMP 0xC5 -> 0x05
    bus.flags = 3'b001;
    tick();
    chk("pc_after_add", 32'(bus.pc), 32'h1);
    chk("fetch_func", 32'(bus.func), 32'h0);

    tick();  // EXEC ADDI, F <= 001
    chk("addi_func", 32'(bus.func), 32'h2);
    chk("addi_isel", 32'(bus.imm_sel), 32'h1);
    chk("addi_imm", 32'(bus.imm), 32'h05);
    chk("addi_rd", 32'(bus.rd_addr), 32'h2);
    chk("addi_wen", 32'(bus.w_en), 32'h1);
    tick();
    bus.flags = 3'b000;     // live flags disagree with stored F
    chk("pc_after_addi", 32'(bus.pc), 32'h2);

    tick();  // EXEC BEQ
    chk("beq_wen", 32'(bus.w_en), 32'h0);
    chk("beq_func", 32'(bus.func), 32'h0);
    tick();
    chk("beq_taken_pc", 32'(bus.pc), 32'h2A);

    bus.flags = 3'b110;
    tick();  // EXEC SUB, F <= 110
    chk("sub_func", 32'(bus.func), 32'h3);
    chk("sub_wen", 32'(bus.w_en), 32'h1);
    tick();
    bus.flags = 3'b001;
    chk("pc_after_sub", 32'(bus.pc), 32'h2B);

    tick();  // EXEC BNE
    chk("bne_wen", 32'(bus.w_en), 32'h0);
    tick();
    chk("bne_taken_pc", 32'(bus.pc), 32'h10);

    tick();  // EXEC BEQ, not taken
    chk("beq_nt_wen", 32'(bus.w_en), 32'h0);
    tick();
    chk("beq_nt_pc", 32'(bus.pc), 32'h11);

    tick(); tick();
    chk("jmp_pc", 32'(bus.pc), 32'h3F);
    tick();  // EXEC op D
    chk("opd_wen", 32'(bus.w_en), 32'h0);
    chk("opd_func", 32'(bus.func), 32'h0);
    tick();
    chk("wrap_pc", 32'(bus.pc), 32'h0);
    tick(); tick();
    chk("jmp_trunc_pc", 32'(bus.pc), 32'h05);

    bus.flags = 3'b101;
    tick();  // EXEC XOR
    chk("xor_func", 32'(bus.func), 32'h6);
    chk("xor_rd", 32'(bus.rd_addr), 32'h3);
    chk("xor_rs", 32'(bus.rs_addr), 32'h4);
    tick();
    bus.flags = 3'b000;
    tick();  // EXEC MOV
    chk("mov_func", 32'(bus.func), 32'h1);
    chk("mov_wen", 32'(bus.w_en), 32'h1);
    tick();
    chk("pc_before_halt", 32'(bus.pc), 32'h7);

    tick();  // EXEC HALT
    chk("halt_exec_wen", 32'(bus.w_en), 32'h0);
    chk("halt_exec_flag", 32'(bus.halt), 32'h0);
    tick();
    chk("halt_flag", 32'(bus.halt), 32'h1);
    chk("halt_pc", 32'(bus.pc), 32'h7);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("halted_flag", 32'(bus.halt), 32'h1);
      chk("halted_pc", 32'(bus.pc), 32'h7);
      chk("halted_wen", 32'(bus.w_en), 32'h0);
    end

    nReset = 1'b0;
    #1;
    chk("hrst_halt", 32'(bus.halt), 32'h0);
    chk("hrst_pc", 32'(bus.pc), 32'h0);
    mem[0] = 20'h80000;     // ADDI r0,0
    bus.flags = 3'b001;
    @(negedge clk);
    nReset = 1'b1;
    tick(); tick();         // ADDI, F <= 001
    tick(); tick();         // ADDI, F <= 001
    bus.flags = 3'b000;
    chk("pre_beq_pc", 32'(bus.pc), 32'h2);
    tick();  // EXEC BEQ (would be taken)
    chk("beq2_wen", 32'(bus.w_en), 32'h0);
    mem[0] = 20'hA0030;     // BEQ 0x30, not taken once F is cleared
    nReset = 1'b0;
    #1;
    chk("mid_rst_pc", 32'(bus.pc), 32'h0);
    chk("mid_rst_func", 32'(bus.func), 32'h0);
    chk("mid_rst_halt", 32'(bus.halt), 32'h0);
    @(posedge clk);
    #1;
    chk("mid_rst_hold_pc", 32'(bus.pc), 32'h0);
    @(negedge clk);
    nReset = 1'b1;
    tick();  // EXEC BEQ from address 0
    chk("post_rst_wen", 32'(bus.w_en), 32'h0);
    chk("post_rst_pc", 32'(bus.pc), 32'h0);
    tick();
    chk("f_cleared_pc", 32'(bus.pc), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
